reg_mux_stage: RTL and testbench
================================

REG_MUX_STAGE -- requirements
Module: reg_mux_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width in bits of each input and the output.
REQ-002 The block SHALL have parameter NUM_IN, default 4, meaning number of selectable inputs (legal range 2..16).
REQ-003 The block SHALL have localparam SEL_W = max(1, ceil(log2(NUM_IN))), meaning select width.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port in_data, input, NUM_IN*WIDTH bits, meaning packed inputs, input k at bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_sel, input, SEL_W bits, meaning index of the input to forward.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning the producer offers in_data/in_sel this cycle.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts this cycle.
REQ-010 The block SHALL have port flush, input, 1 bit, meaning synchronous discard of all held entries.
REQ-011 The block SHALL have port out_data, output, WIDTH bits, meaning the selected word at the head of the stage.
REQ-012 The block SHALL have port out_err, output, 1 bit, meaning the head entry had in_sel >= NUM_IN.
REQ-013 The block SHALL have port out_valid, output, 1 bit, meaning out_data/out_err are valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the head entry this cycle.
REQ-015 The block SHALL have port xfer_cnt, output, 16 bits, meaning count of completed output transfers.

Function
REQ-016 Accept SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-017 On accept, the captured entry SHALL be {word in_sel of in_data, err=0}, or {all zeros, err=1} if in_sel >= NUM_IN.
REQ-018 Storage SHALL be two entries, head (drives outputs) and skid; states EMPTY, ONE, TWO.
REQ-019 EMPTY: accept -> ONE with head loaded; else stay EMPTY.
REQ-020 ONE: accept and transfer -> ONE with head reloaded; accept only -> TWO with skid loaded; transfer only -> EMPTY; neither -> ONE.
REQ-021 TWO: transfer -> ONE with head <= skid; no accept possible; no transfer -> TWO.
REQ-022 in_ready SHALL equal 1 exactly when state != TWO, driven from a register (no combinational path from out_ready).
REQ-023 out_valid SHALL equal 1 exactly when state != EMPTY; out_data/out_err SHALL be driven directly from the head register.
REQ-024 Latency SHALL be one cycle: data accepted at edge N is visible on out_data after edge N when state was EMPTY.
REQ-025 Head and skid contents SHALL be stable while out_valid && !out_ready.
REQ-026 At 100% in_valid and out_ready, throughput SHALL be one word per cycle with no bubbles.
REQ-027 flush=1 SHALL force state EMPTY at the next edge, overriding any simultaneous accept or transfer; a transfer in that cycle still counts.
REQ-028 xfer_cnt SHALL increment by one per output transfer and wrap from 16'hFFFF to 16'h0000.

Reset
REQ-029 While rst_n=0, state SHALL be EMPTY, out_valid=0, in_ready=0, out_data=0, out_err=0, xfer_cnt=0, asynchronously.
REQ-030 in_ready SHALL rise at the first clk edge after rst_n deasserts; reset asserted mid-transfer SHALL discard all entries.

Verification
REQ-031 WIDTH=32, NUM_IN=4, in_data={4,3,2,1}, in_sel=2, in_valid=1, out_ready=1 -> out_data=3, out_err=0 one cycle later.
REQ-032 in_sel=3'd5 with NUM_IN=5 (SEL_W=3) -> out_data=0, out_err=1, out_valid=1.
REQ-033 out_ready=0, two accepts of 0xA and 0xB -> in_ready=0 after 2nd; out_ready=1 -> 0xA then 0xB on consecutive cycles, in_ready=1 after first.
REQ-034 State TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry retained.
REQ-035 Continuous streaming of 70000 words -> xfer_cnt equals 70000 mod 65536 = 4464, no bubbles.
REQ-036 rst_n pulsed low asynchronously while in state ONE -> out_valid=0, xfer_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_mux_stage.sv
// Registered N:1 word selector with a two-entry head/skid buffer and a
// wrapping count of completed output transfers.
module reg_mux_stage #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  localparam int unsigned SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             xfer_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             head_err_q, head_err_d;
  logic             skid_err_q, skid_err_d;
  logic             in_ready_q, in_ready_d;
  logic [15:0]      xfer_cnt_q, xfer_cnt_d;
  logic [WIDTH-1:0] cap_data;
  logic             cap_err;
  logic             accept, xfer;

  // An out-of-range select matches no input and leaves the error entry.
  always_comb begin
    cap_data = '0;
    cap_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (32'(in_sel) == k) begin
        cap_data = in_data[k*WIDTH +: WIDTH];
        cap_err  = 1'b0;
      end
    end
  end

  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready_q;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_err_d  = head_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    xfer_cnt_d  = xfer_cnt_q + {15'd0, xfer};

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          head_data_d = cap_data;
          head_err_d  = cap_err;
          state_d     = StOne;
        end
      end
      StOne: begin
        if (accept && xfer) begin
          head_data_d = cap_data;
          head_err_d  = cap_err;
        end else if (accept) begin
          skid_data_d = cap_data;
          skid_err_d  = cap_err;
          state_d     = StTwo;
        end else if (xfer) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (xfer) begin
          head_data_d = skid_data_q;
          head_err_d  = skid_err_q;
          state_d     = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Flush drops every entry but the transfer it coincides with still counts.
    if (flush) begin
      state_d     = StEmpty;
      head_data_d = head_data_q;
      head_err_d  = head_err_q;
      skid_data_d = skid_data_q;
      skid_err_d  = skid_err_q;
    end

    in_ready_d = (state_d != StTwo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      head_data_q <= '0;
      head_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      xfer_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_err_q  <= head_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      in_ready_q  <= in_ready_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_data = head_data_q;
  assign out_err  = head_err_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_reg_mux_stage.sv
// Self-checking bench for reg_mux_stage: directed scenarios plus random traffic
// compared against a queue-based model of the stage.
module tb_reg_mux_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid, in_ready, flush;
  logic [31:0]  out_data;
  logic         out_err, out_valid, out_ready;
  logic [15:0]  xfer_cnt;

  // Five-input instance used for the out-of-range select case.
  logic [159:0] in_data5;
  logic [2:0]   in_sel5;
  logic         in_valid5, in_ready5, flush5;
  logic [31:0]  out_data5;
  logic         out_err5, out_valid5, out_ready5;
  logic [15:0]  xfer_cnt5;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO of {err, data}, capacity two.
  logic [32:0] mq[$];
  logic [15:0] m_cnt = 16'd0;
  bit          rdy_ok = 1'b0;

  always #5 clk = ~clk;

  reg_mux_stage #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  reg_mux_stage #(.WIDTH(32), .NUM_IN(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_sel(in_sel5),
    .in_valid(in_valid5), .in_ready(in_ready5), .flush(flush5),
    .out_data(out_data5), .out_err(out_err5), .out_valid(out_valid5),
    .out_ready(out_ready5), .xfer_cnt(xfer_cnt5)
  );

  function automatic logic [32:0] expect_entry(input logic [127:0] d, input int unsigned s);
    if (s >= 4) return {1'b1, 32'd0};
    return {1'b0, 32'(d >> (s * 32))};
  endfunction

  // One clock edge for the NUM_IN=4 instance with the model advanced alongside.
  task automatic tick();
    logic        acc, xf;
    logic [32:0] e;
    acc = in_valid && rdy_ok && (mq.size() < 2);
    xf  = out_ready && (mq.size() > 0);
    e   = expect_entry(in_data, int'(in_sel));
    @(posedge clk);
    if (xf) m_cnt = m_cnt + 16'd1;
    if (flush) mq.delete();
    else begin
      if (xf) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    rdy_ok = 1'b1;
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt  = 16'd0;
    rdy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_err, out_data, xfer_cnt} !== 50'd0) begin
      n_fail++;
      $display("FAIL reset_values: v=%b rdy=%b err=%b data=%h cnt=%h, expected all zero",
               out_valid, in_ready, out_err, out_data, xfer_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: got %b expected 0", in_ready);
    end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_edge: rdy=%b v=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_select();
    in_data   = {32'd4, 32'd3, 32'd2, 32'd1};
    in_sel    = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_data !== 32'd3 || out_err !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL select_word2: data=%h err=%b v=%b expected 3/0/1", out_data, out_err, out_valid);
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || xfer_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL select_drain: v=%b cnt=%0d expected 0/%0d", out_valid, xfer_cnt, m_cnt);
    end
  endtask

  task automatic test_err();
    in_data5   = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    in_sel5    = 3'd5;
    in_valid5  = 1'b1;
    out_ready5 = 1'b1;
    @(posedge clk);
    #1;
    in_valid5 = 1'b0;
    n_checks++;
    if (out_data5 !== 32'd0 || out_err5 !== 1'b1 || out_valid5 !== 1'b1) begin
      n_fail++;
      $display("FAIL sel_out_of_range: data=%h err=%b v=%b expected 0/1/1",
               out_data5, out_err5, out_valid5);
    end
    in_sel5   = 3'd4;
    in_valid5 = 1'b1;
    @(posedge clk);
    #1;
    in_valid5 = 1'b0;
    n_checks++;
    if (out_data5 !== 32'd5 || out_err5 !== 1'b0) begin
      n_fail++;
      $display("FAIL sel_top_input: data=%h err=%b expected 5/0", out_data5, out_err5);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 128'hA;
    tick();
    in_data = 128'hB;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || out_data !== 32'hA || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: rdy=%b data=%h v=%b expected 0/a/1", in_ready, out_data, out_valid);
    end
    tick();
    n_checks++;
    if (out_data !== 32'hA || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: data=%h rdy=%b expected a/0", out_data, in_ready);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_data !== 32'hB || out_valid !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: data=%h v=%b rdy=%b expected b/1/1", out_data, out_valid, in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || xfer_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL bp_drained: v=%b cnt=%0d expected 0/%0d", out_valid, xfer_cnt, m_cnt);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_in_two: v=%b rdy=%b expected 0/1", out_valid, in_ready);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_retained: v=%b expected 0", out_valid);
    end
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || xfer_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL flush_with_xfer: v=%b cnt=%0d expected 0/%0d", out_valid, xfer_cnt, m_cnt);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_sel    = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
      n_checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          xfer_cnt !== m_cnt ||
          (mq.size() > 0 && {out_err, out_data} !== mq[0])) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle%0d: v=%b rdy=%b err=%b data=%h cnt=%0d expected size=%0d head=%h cnt=%0d",
                   i, out_valid, in_ready, out_err, out_data, xfer_cnt, mq.size(),
                   (mq.size() > 0) ? mq[0] : 33'd0, m_cnt);
      end
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    in_data   = {32'h12345678, 96'd0};
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL pre_async_reset: v=%b data=%h expected 1/12345678", out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || xfer_cnt !== 16'd0 || in_ready !== 1'b0 || out_data !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b cnt=%0d rdy=%b data=%h expected 0/0/0/0",
               out_valid, xfer_cnt, in_ready, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    int bubbles = 0;
    int data_bad = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_sel    = 2'd0;
    for (int i = 0; i < 70000; i++) begin
      in_data = {96'd0, 32'(i)};
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b1) bubbles++;
      if (out_data !== 32'(i)) data_bad++;
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (bubbles != 0 || data_bad != 0) begin
      n_fail++;
      $display("FAIL stream_bubbles: bubbles=%0d bad_words=%0d expected 0/0", bubbles, data_bad);
    end
    n_checks++;
    if (xfer_cnt !== 16'd4464 || xfer_cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL stream_count: cnt=%0d expected 4464", xfer_cnt);
    end
  endtask

  initial begin
    in_data    = '0;
    in_sel     = '0;
    in_valid   = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    in_data5   = '0;
    in_sel5    = '0;
    in_valid5  = 1'b0;
    flush5     = 1'b0;
    out_ready5 = 1'b1;
    test_reset();
    test_select();
    test_err();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    test_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
